// File: rtl/decoder_pkg.sv
// Shared decode definitions: instruction field layout, opcodes, FSM states and the control bundle
// handed from the decode stage to execute.
package decoder_pkg;

    localparam int INST_W         = 16;
    localparam int DATA_W         = 8;
    localparam int IMM_W          = 16;
    localparam int I_ADDR_W       = 12;
    localparam int REG_ADDR_WIDTH = 4;

    localparam int OPCODE_MSB         = 15;
    localparam int OPCODE_LSB         = 12;
    localparam int REG_FIELD_MSB      = 11;
    localparam int REG_FIELD_LSB      = 8;
    localparam int DATA_IMMEDIATE_MSB = DATA_W - 1;
    localparam int DATA_IMMEDIATE_LSB = 0;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS = 4'hF;
    localparam logic [2:0]                ALU_SUB    = 3'd1;

    // Conditional branches carry their condition code in the two low opcode bits.
    typedef enum logic [3:0] {
        OPCODE_NOP   = 4'h0,
        OPCODE_SET   = 4'h1,
        OPCODE_ALUI  = 4'h2,
        OPCODE_ALUR  = 4'h3,
        OPCODE_GET   = 4'h4,
        OPCODE_PUT   = 4'h5,
        OPCODE_LOAD  = 4'h6,
        OPCODE_STORE = 4'h7,
        OPCODE_JUMP  = 4'h8,
        OPCODE_CMPI  = 4'h9,
        OPCODE_BRZ   = 4'hC,
        OPCODE_BRNZ  = 4'hD,
        OPCODE_BRC   = 4'hE,
        OPCODE_EXT   = 4'hF
    } opcode_e;

    typedef enum logic {
        NORMAL   = 1'b0,
        PREFIXED = 1'b1
    } decode_state_e;

    typedef struct packed {
        logic                      acc_write_enable;
        logic                      write_put_acc;
        logic                      read_get_acc;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        logic                      read_data_output_enable;
        logic                      status_write_enable;
        logic                      data_memory_write_enable;
        logic                      data_memory_output_enable;
        logic                      jump_branch_select;
        logic                      immediate_address_select;
        logic                      unconditional_branch;
        logic [1:0]                branch_condition;
        logic                      pc_relative;
        logic                      alu_output_enable;
        logic [2:0]                alu_function;
        logic                      imm_to_acc;
        logic                      imm_to_alu_b;
    } decode_ctrl_t;

    function automatic logic uses_data_imm(decode_ctrl_t c);
        return c.imm_to_acc || c.imm_to_alu_b;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction -> control bundle translation; no state, no handshake.
// Unknown opcodes and EXT decode to an all-zero bundle (no-op).
module decode_logic
    import decoder_pkg::*;
(
    input  logic [INST_W-1:0] instruction,
    output decode_ctrl_t      ctrl
);

    logic [3:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] reg_field;
    logic                      unused_imm_bits;

    assign opcode          = instruction[OPCODE_MSB:OPCODE_LSB];
    assign reg_field       = instruction[REG_FIELD_MSB:REG_FIELD_LSB];
    assign unused_imm_bits = ^instruction[7:3];

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPCODE_SET: begin
                ctrl.imm_to_acc       = 1'b1;
                ctrl.acc_write_enable = 1'b1;
            end
            OPCODE_ALUI: begin
                ctrl.imm_to_alu_b      = 1'b1;
                ctrl.alu_output_enable = 1'b1;
                ctrl.acc_write_enable  = 1'b1;
                ctrl.alu_function      = instruction[10:8];
            end
            OPCODE_ALUR: begin
                ctrl.read_data_output_enable = 1'b1;
                ctrl.reg_addr                = reg_field;
                ctrl.alu_output_enable       = 1'b1;
                ctrl.acc_write_enable        = 1'b1;
                ctrl.alu_function            = instruction[2:0];
            end
            OPCODE_GET: begin
                ctrl.read_get_acc            = 1'b1;
                ctrl.read_data_output_enable = 1'b1;
                ctrl.reg_addr                = reg_field;
                ctrl.acc_write_enable        = 1'b1;
            end
            OPCODE_PUT: begin
                ctrl.write_put_acc = 1'b1;
                ctrl.reg_addr      = reg_field;
            end
            OPCODE_LOAD: begin
                ctrl.immediate_address_select  = 1'b1;
                ctrl.data_memory_output_enable = 1'b1;
                ctrl.acc_write_enable          = 1'b1;
            end
            OPCODE_STORE: begin
                ctrl.immediate_address_select = 1'b1;
                ctrl.data_memory_write_enable = 1'b1;
            end
            OPCODE_JUMP: begin
                ctrl.jump_branch_select   = 1'b1;
                ctrl.unconditional_branch = 1'b1;
            end
            OPCODE_CMPI: begin
                ctrl.imm_to_alu_b        = 1'b1;
                ctrl.alu_output_enable   = 1'b1;
                ctrl.status_write_enable = 1'b1;
                ctrl.alu_function        = ALU_SUB;
            end
            OPCODE_BRZ, OPCODE_BRNZ, OPCODE_BRC: begin
                // The condition is evaluated against the status register, so read it out.
                ctrl.jump_branch_select      = 1'b1;
                ctrl.pc_relative             = 1'b1;
                ctrl.reg_addr                = REG_STATUS;
                ctrl.read_data_output_enable = 1'b1;
                ctrl.branch_condition        = opcode[1:0];
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with EXT prefix handling: one cycle latency, valid/ready on both sides;
// outputs hold while out_valid && !out_ready, and flush discards the held output and any prefix.
module decode_stage
    import decoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [INST_W-1:0]   instruction,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output decode_ctrl_t        ctrl,
    output logic [IMM_W-1:0]    data_immediate,
    output logic [I_ADDR_W-1:0] address_immediate,
    output logic                prefix_pending,
    output logic                prefix_dropped
);

    decode_ctrl_t dec;

    decode_logic u_decode_logic (
        .instruction (instruction),
        .ctrl        (dec)
    );

    decode_state_e        state_q, state_d;
    logic [DATA_W-1:0]    ext_q, ext_d;
    logic                 dropped_q, dropped_d;
    logic                 out_valid_q, out_valid_d;
    decode_ctrl_t         ctrl_q, ctrl_d;
    logic [IMM_W-1:0]     data_imm_q, data_imm_d;
    logic [I_ADDR_W-1:0]  addr_imm_q, addr_imm_d;

    logic                 accept;
    logic                 is_ext;
    logic                 uses_imm;
    logic [DATA_W-1:0]    low_imm;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_ext   = (instruction[OPCODE_MSB:OPCODE_LSB] == OPCODE_EXT);
    assign uses_imm = uses_data_imm(dec);
    assign low_imm  = instruction[DATA_IMMEDIATE_MSB:DATA_IMMEDIATE_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= NORMAL;
            ext_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ext_d     = ext_q;
        dropped_d = 1'b0;
        if (flush) begin
            state_d   = NORMAL;
            dropped_d = (state_q == PREFIXED);
        end else if (accept) begin
            if (is_ext) begin
                ext_d     = low_imm;
                state_d   = PREFIXED;
                dropped_d = (state_q == PREFIXED);
            end else begin
                // A prefix survives only into an instruction that consumes a data immediate.
                state_d   = NORMAL;
                dropped_d = (state_q == PREFIXED) && !uses_imm;
            end
        end
    end

    assign prefix_pending = (state_q == PREFIXED);
    assign prefix_dropped = dropped_q;

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        ctrl_d      = ctrl_q;
        data_imm_d  = data_imm_q;
        addr_imm_d  = addr_imm_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept && !is_ext) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec;
            addr_imm_d  = instruction[I_ADDR_W-1:0];
            if ((state_q == PREFIXED) && uses_imm) begin
                data_imm_d = {ext_q[IMM_W-DATA_W-1:0], low_imm};
            end else begin
                data_imm_d = {{(IMM_W-DATA_W){1'b0}}, low_imm};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            data_imm_q  <= '0;
            addr_imm_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            data_imm_q  <= data_imm_d;
            addr_imm_q  <= addr_imm_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign ctrl              = ctrl_q;
    assign data_immediate    = data_imm_q;
    assign address_immediate = addr_imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and random stimulus against a transaction-level model of the decode stage.
module tb_decode_stage;
    import decoder_pkg::*;

    logic                clk = 1'b0;
    logic                reset, flush, in_valid, out_ready;
    logic [15:0]         instruction;
    logic                in_ready, out_valid, prefix_pending, prefix_dropped;
    decode_ctrl_t        ctrl;
    logic [15:0]         data_immediate;
    logic [11:0]         address_immediate;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .instruction       (instruction),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .ctrl              (ctrl),
        .data_immediate    (data_immediate),
        .address_immediate (address_immediate),
        .prefix_pending    (prefix_pending),
        .prefix_dropped    (prefix_dropped)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: the last transfer presented to execute plus the held prefix.
    bit           m_v, m_pend, m_drop;
    decode_ctrl_t m_ctrl;
    int           m_dimm, m_aimm, m_ext;

    function automatic decode_ctrl_t ref_ctrl(logic [15:0] ins);
        decode_ctrl_t c;
        int op;
        c  = '0;
        op = int'(ins[15:12]);
        if (op == 1) begin
            c.imm_to_acc = 1; c.acc_write_enable = 1;
        end else if (op == 2) begin
            c.imm_to_alu_b = 1; c.alu_output_enable = 1; c.acc_write_enable = 1;
            c.alu_function = ins[10:8];
        end else if (op == 3) begin
            c.read_data_output_enable = 1; c.reg_addr = ins[11:8];
            c.alu_output_enable = 1; c.acc_write_enable = 1; c.alu_function = ins[2:0];
        end else if (op == 4) begin
            c.read_get_acc = 1; c.read_data_output_enable = 1;
            c.reg_addr = ins[11:8]; c.acc_write_enable = 1;
        end else if (op == 5) begin
            c.write_put_acc = 1; c.reg_addr = ins[11:8];
        end else if (op == 6) begin
            c.immediate_address_select = 1; c.data_memory_output_enable = 1; c.acc_write_enable = 1;
        end else if (op == 7) begin
            c.immediate_address_select = 1; c.data_memory_write_enable = 1;
        end else if (op == 8) begin
            c.jump_branch_select = 1; c.unconditional_branch = 1;
        end else if (op == 9) begin
            c.imm_to_alu_b = 1; c.alu_output_enable = 1; c.status_write_enable = 1;
            c.alu_function = 3'd1;
        end else if (op >= 12 && op <= 14) begin
            c.jump_branch_select = 1; c.pc_relative = 1; c.reg_addr = 4'hF;
            c.read_data_output_enable = 1; c.branch_condition = 2'(op - 12);
        end
        return c;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit r, bit f, bit iv, logic [15:0] ins, bit ordy);
        bit           rdy, uses;
        decode_ctrl_t e;
        reset = r; flush = f; in_valid = iv; instruction = ins; out_ready = ordy;
        #1;
        rdy = !f && (!m_v || ordy);
        if (!r) check("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        if (r) begin
            m_v = 0; m_pend = 0; m_drop = 0; m_ctrl = '0; m_dimm = 0; m_aimm = 0; m_ext = 0;
        end else begin
            m_drop = 0;
            if (f) begin
                m_drop = m_pend; m_pend = 0; m_v = 0;
            end else begin
                if (m_v && ordy) m_v = 0;
                if (iv && rdy) begin
                    if (ins[15:12] == 4'hF) begin
                        m_drop = m_pend; m_pend = 1; m_ext = int'(ins[7:0]);
                    end else begin
                        e      = ref_ctrl(ins);
                        uses   = e.imm_to_acc || e.imm_to_alu_b;
                        m_dimm = (m_pend && uses) ? m_ext * 256 + int'(ins[7:0]) : int'(ins[7:0]);
                        m_drop = m_pend && !uses;
                        m_pend = 0; m_v = 1; m_ctrl = e; m_aimm = int'(ins[11:0]);
                    end
                end
            end
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_v));
        check("prefix_pending", 64'(prefix_pending), 64'(m_pend));
        check("prefix_dropped", 64'(prefix_dropped), 64'(m_drop));
        if (m_v || r) begin
            check("ctrl", 64'(ctrl), 64'(m_ctrl));
            check("data_immediate", 64'(data_immediate), 64'(m_dimm));
            check("address_immediate", 64'(address_immediate), 64'(m_aimm));
        end
    endtask

    initial begin
        m_v = 0; m_pend = 0; m_drop = 0; m_ctrl = '0; m_dimm = 0; m_aimm = 0; m_ext = 0;
        step(1, 0, 0, 16'h0000, 1);
        step(1, 0, 0, 16'h0000, 1);
        check("reset_ctrl_zero", 64'(ctrl), 64'd0);

        // SET 0x5A
        step(0, 0, 1, 16'h105A, 1);
        check("set_valid", 64'(out_valid), 64'd1);
        check("set_imm_to_acc", 64'(ctrl.imm_to_acc), 64'd1);
        check("set_acc_we", 64'(ctrl.acc_write_enable), 64'd1);
        check("set_dimm", 64'(data_immediate), 64'h005A);

        // EXT 0x12 then ALU-immediate 0x34
        step(0, 0, 1, 16'hF012, 1);
        check("ext_no_output", 64'(out_valid), 64'd0);
        check("ext_pending", 64'(prefix_pending), 64'd1);
        step(0, 0, 1, 16'h2134, 1);
        check("alui_dimm", 64'(data_immediate), 64'h1234);
        check("alui_imm_to_alu_b", 64'(ctrl.imm_to_alu_b), 64'd1);
        check("alui_pending_clear", 64'(prefix_pending), 64'd0);

        // EXT, EXT, SET: second EXT replaces the first
        step(0, 0, 1, 16'hF012, 1);
        step(0, 0, 1, 16'hF07F, 1);
        check("ext2_dropped", 64'(prefix_dropped), 64'd1);
        step(0, 0, 1, 16'h1001, 1);
        check("ext2_drop_once", 64'(prefix_dropped), 64'd0);
        check("ext2_dimm", 64'(data_immediate), 64'h7F01);

        // Stall three cycles, then release with nothing new offered
        step(0, 0, 1, 16'h1033, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 16'h1044, 0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_dimm_hold", 64'(data_immediate), 64'h0033);
        end
        step(0, 0, 0, 16'h1044, 1);
        check("release_single", 64'(out_valid), 64'd0);

        // EXT then flush (with a valid instruction that must be ignored)
        step(0, 0, 1, 16'hF0AB, 1);
        step(0, 1, 1, 16'h1055, 1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_dropped", 64'(prefix_dropped), 64'd1);
        step(0, 0, 1, 16'h1002, 1);
        check("post_flush_dimm", 64'(data_immediate), 64'h0002);

        // Branch while prefixed
        step(0, 0, 1, 16'hF0CD, 1);
        step(0, 0, 1, 16'hC123, 1);
        check("br_dropped", 64'(prefix_dropped), 64'd1);
        check("br_reg_status", 64'(ctrl.reg_addr), 64'hF);
        check("br_jbs", 64'(ctrl.jump_branch_select), 64'd1);
        check("br_pcrel", 64'(ctrl.pc_relative), 64'd1);

        // Flush and reset together while prefixed: reset wins, no drop pulse
        step(0, 0, 1, 16'hF011, 1);
        step(1, 1, 1, 16'h1000, 1);
        check("rst_flush_no_drop", 64'(prefix_dropped), 64'd0);

        // Reset during a stall
        step(0, 0, 1, 16'h1077, 1);
        step(0, 0, 1, 16'h1078, 0);
        step(1, 0, 0, 16'h0000, 0);
        check("rst_stall_valid", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0]  op;
            logic [11:0] body;
            op   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'hF;
            body = 12'($urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), {op, body}, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
